// File: rtl/rgb565_roi_gray.sv
// RGB565 camera front-end: crops a fixed ROI and converts it to 8-bit grey for the pooling stage.
// Optional macro ROI_FRAME_CHECK_EN adds a sticky frame_err output for wrong per-frame pixel counts.
module rgb565_roi_gray #(
    parameter int SRC_WIDTH  = 640,
    parameter int CROP_X     = 264,
    parameter int CROP_Y     = 184,
    parameter int OUT_WIDTH  = 112,
    parameter int OUT_HEIGHT = 112
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_de,
    input  logic [15:0] cam_data,
    output logic        frame_start,
    output logic [7:0]  pixel_out,
    output logic        pixel_valid_out
`ifdef ROI_FRAME_CHECK_EN
    ,
    output logic        frame_err
`endif
);

    // The window never extends past the active source line.
    localparam int X_END = (CROP_X + OUT_WIDTH < SRC_WIDTH) ? CROP_X + OUT_WIDTH : SRC_WIDTH;

    localparam logic [10:0] X_LO    = 11'(CROP_X);
    localparam logic [10:0] X_HI    = 11'(X_END);
    localparam logic [10:0] Y_LO    = 11'(CROP_Y);
    localparam logic [10:0] Y_HI    = 11'(CROP_Y + OUT_HEIGHT);
    localparam logic [10:0] CNT_SAT = 11'h7FF;

    logic        vsync_q, vsync_q2;
    logic        de_q, de_q2;
    logic [15:0] data_q;
    logic        locked;
    logic [10:0] col_cnt, row_cnt;

    logic        vs_rise, de_fall, keep;
    logic [7:0]  r8, g8, b8;

    logic        s1_valid;
    logic [15:0] prod_r, prod_g, prod_b;

    assign vs_rise = vsync_q & ~vsync_q2;
    assign de_fall = de_q2 & ~de_q;

    assign keep = locked & de_q &
                  (col_cnt >= X_LO) & (col_cnt < X_HI) &
                  (row_cnt >= Y_LO) & (row_cnt < Y_HI);

    assign r8 = {data_q[15:11], data_q[15:13]};
    assign g8 = {data_q[10:5],  data_q[10:9]};
    assign b8 = {data_q[4:0],   data_q[4:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
            de_q     <= 1'b0;
            de_q2    <= 1'b0;
            data_q   <= 16'd0;
            locked   <= 1'b0;
            col_cnt  <= 11'd0;
            row_cnt  <= 11'd0;
        end else begin
            vsync_q  <= cam_vsync;
            vsync_q2 <= vsync_q;
            de_q     <= cam_de;
            de_q2    <= de_q;
            data_q   <= cam_data;
            if (vs_rise) begin
                locked <= 1'b1;
            end
            // vs_rise has priority so a line ending on the sync edge cannot bump row 0.
            if (vs_rise) begin
                col_cnt <= 11'd0;
                row_cnt <= 11'd0;
            end else if (de_fall) begin
                col_cnt <= 11'd0;
                if (row_cnt != CNT_SAT) begin
                    row_cnt <= row_cnt + 11'd1;
                end
            end else if (de_q && (col_cnt != CNT_SAT)) begin
                col_cnt <= col_cnt + 11'd1;
            end
        end
    end

    // Two-stage luma: weighted products, then sum and keep the integer part.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid        <= 1'b0;
            prod_r          <= 16'd0;
            prod_g          <= 16'd0;
            prod_b          <= 16'd0;
            pixel_out       <= 8'd0;
            pixel_valid_out <= 1'b0;
            frame_start     <= 1'b0;
        end else begin
            s1_valid        <= keep & ~vs_rise;
            prod_r          <= 16'd77  * {8'd0, r8};
            prod_g          <= 16'd150 * {8'd0, g8};
            prod_b          <= 16'd29  * {8'd0, b8};
            pixel_valid_out <= s1_valid & ~vs_rise;
            if (s1_valid) begin
                pixel_out <= 8'(({1'b0, prod_r} + {1'b0, prod_g} + {1'b0, prod_b}) >> 8);
            end
            frame_start <= vs_rise;
        end
    end

`ifdef ROI_FRAME_CHECK_EN
    localparam logic [14:0] FRAME_PIXELS = 15'(OUT_WIDTH * OUT_HEIGHT);

    logic [13:0] pix_cnt;

    // The pixel leaving in the vs_rise cycle itself still belongs to the old frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt   <= 14'd0;
            frame_err <= 1'b0;
        end else if (vs_rise) begin
            if (locked && (({1'b0, pix_cnt} + 15'(pixel_valid_out)) != FRAME_PIXELS)) begin
                frame_err <= 1'b1;
            end
            pix_cnt <= 14'd0;
        end else if (pixel_valid_out && (pix_cnt != 14'h3FFF)) begin
            pix_cnt <= pix_cnt + 14'd1;
        end
    end
`endif

endmodule
